sata_transport_tx_arbiter: RTL and testbench

Transport-layer transmit scheduler that shares the single link-layer TX AXI-Stream channel between two FIS sources. The command source carries register FIS. The data source carries the sliced 0x46 data FIS produced by the transport packet block. Grants are whole-packet (SOP to EOP), so FIS frames never interleave. Data FIS grants are gated by DMA Activate credits received from the RX side.

---
 rtl/sata_transport_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_sata_transport_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_transport_tx_arbiter.sv
// Whole-packet arbiter sharing the link TX stream between cmd and data FIS sources; grant registered one cycle after SOP, zero-latency pass-through once granted.
// Data grants gated by DMA Activate credits; SATA_TX_ARB_RR_EN selects round-robin ties (default: cmd has fixed priority).
module sata_transport_tx_arbiter #(
  parameter int USER_W = 8,
  parameter int CRED_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_cmd_tdata,
  input  logic [USER_W-1:0] s_cmd_tuser,
  input  logic              s_cmd_tvalid,
  output logic              s_cmd_tready,
  input  logic [31:0]       s_dat_tdata,
  input  logic [USER_W-1:0] s_dat_tuser,
  input  logic              s_dat_tvalid,
  output logic              s_dat_tready,
  output logic [31:0]       m_link_tdata,
  output logic [USER_W-1:0] m_link_tuser,
  output logic              m_link_tvalid,
  input  logic              m_link_tready,
  input  logic              dma_act_pulse,
  input  logic              cfg_act_gate,
  input  logic              link_abort,
  output logic              grant_cmd,
  output logic              grant_dat,
  output logic [CRED_W-1:0] credit_cnt,
  output logic [7:0]        orphan_cnt
);

  typedef enum logic [1:0] {IDLE, G_CMD, G_DAT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CRED_W-1:0] r_credit;
  logic [7:0]        r_orphan;
  logic              w_cmd_sop;
  logic              w_dat_sop;
  logic              w_pick_dat;
  logic              w_cmd_orph;
  logic              w_dat_orph;
  logic              w_consume;
  logic              w_cred_full;
  logic [8:0]        w_orph_sum;

  assign w_cmd_sop   = s_cmd_tvalid & s_cmd_tuser[1];
  assign w_dat_sop   = s_dat_tvalid & s_dat_tuser[1] & (~cfg_act_gate | (r_credit != '0));
  assign w_cmd_orph  = (r_state == IDLE) & s_cmd_tvalid & ~s_cmd_tuser[1] & ~link_abort;
  assign w_dat_orph  = (r_state == IDLE) & s_dat_tvalid & ~s_dat_tuser[1] & ~link_abort;
  assign w_cred_full = (r_credit == {CRED_W{1'b1}});

`ifdef SATA_TX_ARB_RR_EN
  // r_last_dat resets to "data" so the first tie goes to cmd.
  logic r_last_dat;
  assign w_pick_dat = w_dat_sop & (~w_cmd_sop | ~r_last_dat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_dat <= 1'b1;
    else if ((r_state == IDLE) && (w_state_nxt != IDLE))
      r_last_dat <= (w_state_nxt == G_DAT);
  end
`else
  assign w_pick_dat = w_dat_sop & ~w_cmd_sop;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_consume     = 1'b0;
    m_link_tdata  = '0;
    m_link_tuser  = '0;
    m_link_tvalid = 1'b0;
    s_cmd_tready  = 1'b0;
    s_dat_tready  = 1'b0;
    case (r_state)
      IDLE: begin
        s_cmd_tready = w_cmd_orph;
        s_dat_tready = w_dat_orph;
        if (w_pick_dat) begin
          w_state_nxt = G_DAT;
          w_consume   = cfg_act_gate;
        end else if (w_cmd_sop) begin
          w_state_nxt = G_CMD;
        end
      end
      G_CMD: begin
        m_link_tdata  = s_cmd_tdata;
        m_link_tuser  = s_cmd_tuser;
        m_link_tvalid = s_cmd_tvalid;
        s_cmd_tready  = m_link_tready;
        if (s_cmd_tvalid && m_link_tready && s_cmd_tuser[0])
          w_state_nxt = IDLE;
      end
      G_DAT: begin
        m_link_tdata  = s_dat_tdata;
        m_link_tuser  = s_dat_tuser;
        m_link_tvalid = s_dat_tvalid;
        s_dat_tready  = m_link_tready;
        if (s_dat_tvalid && m_link_tready && s_dat_tuser[0])
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over everything: no handshake, no credit use, back to IDLE.
    if (link_abort) begin
      w_state_nxt   = IDLE;
      w_consume     = 1'b0;
      m_link_tvalid = 1'b0;
      s_cmd_tready  = 1'b0;
      s_dat_tready  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_credit <= '0;
    else if (link_abort)
      r_credit <= '0;
    else if (dma_act_pulse && !w_consume && !w_cred_full)
      r_credit <= r_credit + CRED_W'(1);
    else if (w_consume && !dma_act_pulse)
      r_credit <= r_credit - CRED_W'(1);
  end

  assign w_orph_sum = {1'b0, r_orphan} + {8'd0, w_cmd_orph} + {8'd0, w_dat_orph};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_orphan <= '0;
    else
      r_orphan <= (w_orph_sum > 9'd255) ? 8'd255 : w_orph_sum[7:0];
  end

  assign grant_cmd  = (r_state == G_CMD);
  assign grant_dat  = (r_state == G_DAT);
  assign credit_cnt = r_credit;
  assign orphan_cnt = r_orphan;

endmodule

// File: tb/tb_sata_transport_tx_arbiter.sv
// Scoreboard bench: sources drain per-requester beat queues, a negedge monitor checks every
// forwarded link beat against an expected-beat queue; directed checks cover timing, credits, orphans, abort.
module tb_sata_transport_tx_arbiter;
  logic        clk;
  logic        rst_n;
  logic [31:0] s_cmd_tdata, s_dat_tdata, m_link_tdata;
  logic [7:0]  s_cmd_tuser, s_dat_tuser, m_link_tuser;
  logic        s_cmd_tvalid, s_cmd_tready, s_dat_tvalid, s_dat_tready;
  logic        m_link_tvalid, m_link_tready;
  logic        dma_act_pulse, cfg_act_gate, link_abort;
  logic        grant_cmd, grant_dat;
  logic [3:0]  credit_cnt;
  logic [7:0]  orphan_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] cmd_q[$];
  logic [39:0] dat_q[$];
  logic [39:0] exp_q[$];
  logic        c_fire, d_fire;

  sata_transport_tx_arbiter #(.USER_W(8), .CRED_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tuser(s_cmd_tuser),
    .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_dat_tdata(s_dat_tdata), .s_dat_tuser(s_dat_tuser),
    .s_dat_tvalid(s_dat_tvalid), .s_dat_tready(s_dat_tready),
    .m_link_tdata(m_link_tdata), .m_link_tuser(m_link_tuser),
    .m_link_tvalid(m_link_tvalid), .m_link_tready(m_link_tready),
    .dma_act_pulse(dma_act_pulse), .cfg_act_gate(cfg_act_gate),
    .link_abort(link_abort),
    .grant_cmd(grant_cmd), .grant_dat(grant_dat),
    .credit_cnt(credit_cnt), .orphan_cnt(orphan_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Beat = {tuser, tdata}; err on beat 1 and drop on beat 2 of odd tags exercise pass-through.
  function automatic logic [39:0] beat(input logic [7:0] hdr, input logic [7:0] tag, input int i, input int n);
    logic [7:0] u;
    u = {tag[0] & (i == 2), (i == 1), 4'hF, (i == 0), (i == n - 1)};
    return {u, tag, 8'(i), 8'h5A, hdr};
  endfunction

  task automatic send(input bit is_dat, input logic [7:0] hdr, input logic [7:0] tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_dat) dat_q.push_back(beat(hdr, tag, i, n));
      else        cmd_q.push_back(beat(hdr, tag, i, n));
    end
  endtask

  task automatic expect_pkt(input logic [7:0] hdr, input logic [7:0] tag, input int n, input int n_first);
    for (int i = 0; i < n_first; i++) exp_q.push_back(beat(hdr, tag, i, n));
  endtask

  task automatic wait_idle(input string name, input int max);
    int k;
    for (k = 0; k < max; k++) begin
      if (!grant_cmd && !grant_dat && cmd_q.size() == 0 && dat_q.size() == 0) break;
      tick();
    end
    chk(name, 64'(k < max), 64'd1);
  endtask

  // Sources: handshake judged at negedge, queue advanced just after the edge.
  initial begin
    s_cmd_tvalid = 1'b0; s_cmd_tdata = '0; s_cmd_tuser = '0;
    forever begin
      @(negedge clk);
      c_fire = s_cmd_tvalid && s_cmd_tready;
      @(posedge clk);
      #1;
      if (c_fire && cmd_q.size() > 0) void'(cmd_q.pop_front());
      if (cmd_q.size() > 0) begin
        {s_cmd_tuser, s_cmd_tdata} = cmd_q[0];
        s_cmd_tvalid = 1'b1;
      end else begin
        s_cmd_tvalid = 1'b0; s_cmd_tdata = '0; s_cmd_tuser = '0;
      end
    end
  end

  initial begin
    s_dat_tvalid = 1'b0; s_dat_tdata = '0; s_dat_tuser = '0;
    forever begin
      @(negedge clk);
      d_fire = s_dat_tvalid && s_dat_tready;
      @(posedge clk);
      #1;
      if (d_fire && dat_q.size() > 0) void'(dat_q.pop_front());
      if (dat_q.size() > 0) begin
        {s_dat_tuser, s_dat_tdata} = dat_q[0];
        s_dat_tvalid = 1'b1;
      end else begin
        s_dat_tvalid = 1'b0; s_dat_tdata = '0; s_dat_tuser = '0;
      end
    end
  end

  // Monitor: every accepted link beat must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_link_tvalid && m_link_tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL link_beat: got unexpected %h expected none", {m_link_tuser, m_link_tdata});
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          if ({m_link_tuser, m_link_tdata} !== e) begin
            n_fail++;
            $display("FAIL link_beat: got %h expected %h", {m_link_tuser, m_link_tdata}, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   k;
    rst_n = 1'b0; m_link_tready = 1'b0; dma_act_pulse = 1'b0;
    cfg_act_gate = 1'b0; link_abort = 1'b0;
    repeat (3) tick();
    chk("rst_grant_cmd", 64'(grant_cmd), 0);
    chk("rst_grant_dat", 64'(grant_dat), 0);
    chk("rst_link_vld", 64'(m_link_tvalid), 0);
    chk("rst_link_dat", 64'({m_link_tuser, m_link_tdata}), 0);
    chk("rst_treadys", 64'({s_cmd_tready, s_dat_tready}), 0);
    chk("rst_credit", 64'(credit_cnt), 0);
    chk("rst_orphan", 64'(orphan_cnt), 0);
    rst_n = 1'b1;
    m_link_tready = 1'b1;
    tick();

    // 5-beat command FIS: grant one cycle after SOP, five beats without gaps, then IDLE.
    send(0, 8'h27, 8'h10, 5); expect_pkt(8'h27, 8'h10, 5, 5);
    tick();
    chk("a_pre_grant", 64'(grant_cmd), 0);
    tick();
    chk("a_grant_cmd", 64'(grant_cmd), 1);
    ok = m_link_tvalid;
    for (int i = 0; i < 4; i++) begin
      tick();
      ok = ok & m_link_tvalid & grant_cmd;
    end
    chk("a_no_gaps", 64'(ok), 1);
    tick();
    chk("a_idle_after_eop", 64'({grant_cmd, grant_dat}), 0);

    // Credit gating: data SOP stalls until a DMA Activate arrives.
    cfg_act_gate = 1'b1;
    send(1, 8'h46, 8'h20, 3); expect_pkt(8'h46, 8'h20, 3, 3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ok = ok | s_dat_tready | grant_dat;
    end
    chk("b_gated_stall", 64'(ok), 0);
    dma_act_pulse = 1'b1;
    tick();
    dma_act_pulse = 1'b0;
    chk("b_credit_1", 64'(credit_cnt), 1);
    chk("b_no_grant_yet", 64'(grant_dat), 0);
    tick();
    chk("b_grant_dat", 64'(grant_dat), 1);
    chk("b_credit_used", 64'(credit_cnt), 0);
    wait_idle("b_done", 20);
    cfg_act_gate = 1'b0;
    tick();

    // Three packets per requester contending; order decided by the tie policy.
    for (int p = 0; p < 3; p++) begin
      send(0, 8'h27, 8'(8'h30 + p), 2);
      send(1, 8'h46, 8'(8'h40 + p), 2);
    end
`ifdef SATA_TX_ARB_RR_EN
    for (int p = 0; p < 3; p++) begin
      expect_pkt(8'h27, 8'(8'h30 + p), 2, 2);
      expect_pkt(8'h46, 8'(8'h40 + p), 2, 2);
    end
`else
    for (int p = 0; p < 3; p++) expect_pkt(8'h27, 8'(8'h30 + p), 2, 2);
    for (int p = 0; p < 3; p++) expect_pkt(8'h46, 8'(8'h40 + p), 2, 2);
`endif
    wait_idle("c_done", 100);
    chk("c_all_out", 64'(exp_q.size()), 0);

    // Link backpressure toggling mid data packet; command source must stay stalled.
    send(1, 8'h46, 8'h51, 6); expect_pkt(8'h46, 8'h51, 6, 6);
    tick();
    tick();
    chk("d_grant_dat", 64'(grant_dat), 1);
    send(0, 8'h27, 8'h60, 2); expect_pkt(8'h27, 8'h60, 2, 2);
    ok = 1'b0;
    for (k = 0; k < 60; k++) begin
      m_link_tready = ~m_link_tready;
      tick();
      if (!grant_dat) break;
      ok = ok | s_cmd_tready;
    end
    chk("d_dat_finished", 64'(k < 60), 1);
    chk("d_cmd_stalled", 64'(ok), 0);
    m_link_tready = 1'b1;
    wait_idle("d_done", 20);

    // Orphans: non-SOP idle beats are swallowed and counted.
    dat_q.push_back({8'h00, 32'hDEAD0001});
    repeat (4) tick();
    chk("e_orphan_1", 64'(orphan_cnt), 1);
    cmd_q.push_back({8'h40, 32'hDEAD0002});
    dat_q.push_back({8'h80, 32'hDEAD0003});
    repeat (4) tick();
    chk("e_orphan_dual", 64'(orphan_cnt), 3);
    for (int i = 0; i < 300; i++) dat_q.push_back({8'h3C, 32'(i)});
    wait_idle("e_drain", 400);
    tick();
    chk("e_orphan_sat", 64'(orphan_cnt), 255);

    // Abort on the third beat of a credited data packet.
    cfg_act_gate = 1'b1;
    dma_act_pulse = 1'b1;
    repeat (3) tick();
    dma_act_pulse = 1'b0;
    tick();
    chk("f_credit_3", 64'(credit_cnt), 3);
    send(1, 8'h46, 8'h71, 6); expect_pkt(8'h46, 8'h71, 6, 2);
    for (k = 0; k < 10; k++) begin
      tick();
      if (grant_dat) break;
    end
    chk("f_grant_dat", 64'(grant_dat), 1);
    chk("f_credit_2", 64'(credit_cnt), 2);
    tick();
    tick();
    link_abort = 1'b1;
    dat_q.delete();
    #1;
    chk("f_abort_vld", 64'(m_link_tvalid), 0);
    chk("f_abort_rdy", 64'({s_cmd_tready, s_dat_tready}), 0);
    tick();
    link_abort = 1'b0;
    chk("f_idle_after", 64'({grant_cmd, grant_dat}), 0);
    chk("f_credit_clr", 64'(credit_cnt), 0);
    cfg_act_gate = 1'b0;
    repeat (4) tick();
    chk("f_exp_drained", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
